// File: rtl/network_mmio_bridge.sv
// network_mmio_bridge: PicoRV32 look-ahead bus window onto one Hoplite port.
// The CPU fills a staging packet register and commits it into a TX FIFO.
// Received packets queue in an RX FIFO; the CPU reads the head fields, then pops.
// Optional build macro NETWORK_MMIO_COUNTERS_EN adds tx_sent, rx_received and
// rx_backpressure counters at offsets 0x44, 0x48 and 0x4C.
// Handshakes: a beat moves on a cycle where valid and ready are both high; the
// producer holds its data stable while valid is high and ready is low.
module network_mmio_bridge #(
  parameter logic [31:0] BASE_ADDR            = 32'h1000_0100,
  parameter int          COORD_BITS           = 1,
  parameter int          MULTICAST_GROUP_BITS = 1,
  parameter int          MATRIX_TYPE_BITS     = 1,
  parameter int          MATRIX_COORD_BITS    = 8,
  parameter int          MATRIX_ELEMENT_BITS  = 32,
  parameter int          TX_DEPTH             = 4,
  parameter int          RX_DEPTH             = 4,
  // Derived; leave at its default.
  parameter int          PACKET_BITS          = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                                MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS +
                                                MATRIX_ELEMENT_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bus_write,
  input  logic                   bus_read,
  input  logic [31:0]            bus_addr,
  input  logic [31:0]            bus_wdata,
  output logic                   bus_hit,
  output logic [31:0]            bus_rdata,
  output logic [PACKET_BITS-1:0] tx_packet,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [PACKET_BITS-1:0] rx_packet,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   rx_irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);

  // Field positions inside a packet, counted from the LSB.
  localparam int MY_LSB   = MATRIX_ELEMENT_BITS;
  localparam int MX_LSB   = MY_LSB + MATRIX_COORD_BITS;
  localparam int TY_LSB   = MX_LSB + MATRIX_COORD_BITS;
  localparam int RES_BIT  = TY_LSB + MATRIX_TYPE_BITS;
  localparam int DONE_BIT = RES_BIT + 1;
  localparam int MC_LSB   = DONE_BIT + 1;
  localparam int RX_W     = MC_LSB + MULTICAST_GROUP_BITS;  // RX keeps everything below dest

  // Address decode: a 128-byte window, word-indexed.
  logic [31:0] w_off;
  logic [4:0]  w_word;
  logic        w_wr, w_rd, w_commit, w_pop_req, w_status_rd, w_unused;
  assign w_off       = bus_addr - BASE_ADDR;
  assign bus_hit     = (w_off[31:7] == '0);
  assign w_word      = w_off[6:2];
  assign w_wr        = bus_write && bus_hit;
  assign w_rd        = bus_read && bus_hit;
  assign w_commit    = w_wr && (w_word == 5'd8);
  assign w_pop_req   = w_wr && (w_word == 5'd16);
  assign w_status_rd = w_rd && (w_word == 5'd8);
  // Byte lane bits and incoming destination fields carry no information here.
  assign w_unused    = ^{w_off[1:0], rx_packet[PACKET_BITS-1:RX_W]};

  // Staging packet fields
  logic [COORD_BITS-1:0]           r_dest_x, r_dest_y;
  logic [MULTICAST_GROUP_BITS-1:0] r_mcast;
  logic                            r_done, r_result;
  logic [MATRIX_TYPE_BITS-1:0]     r_type;
  logic [MATRIX_COORD_BITS-1:0]    r_mx, r_my;
  logic [MATRIX_ELEMENT_BITS-1:0]  r_element;
  logic [PACKET_BITS-1:0]          w_stage_pkt;
  assign w_stage_pkt = {r_dest_x, r_dest_y, r_mcast, r_done, r_result, r_type, r_mx, r_my, r_element};

  // Field writes land in the staging registers; they persist across COMMITs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dest_x <= '0; r_dest_y <= '0; r_mcast <= '0; r_done <= 1'b0;
      r_result <= 1'b0; r_type <= '0; r_mx <= '0; r_my <= '0; r_element <= '0;
    end else if (w_wr) begin
      case (w_word)
        5'd0: r_dest_x  <= bus_wdata[COORD_BITS-1:0];
        5'd1: r_dest_y  <= bus_wdata[COORD_BITS-1:0];
        5'd2: r_mcast   <= bus_wdata[MULTICAST_GROUP_BITS-1:0];
        5'd3: begin r_done <= bus_wdata[0]; r_result <= bus_wdata[1]; end
        5'd4: r_type    <= bus_wdata[MATRIX_TYPE_BITS-1:0];
        5'd5: r_mx      <= bus_wdata[MATRIX_COORD_BITS-1:0];
        5'd6: r_my      <= bus_wdata[MATRIX_COORD_BITS-1:0];
        5'd7: r_element <= bus_wdata[MATRIX_ELEMENT_BITS-1:0];
        default: ;
      endcase
    end
  end

  // TX FIFO. Fullness is the registered count, so a same-cycle dequeue
  // never makes room for a COMMIT.
  logic [PACKET_BITS-1:0] r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]       r_tx_wr, r_tx_rd;
  logic [TX_CW-1:0]       r_tx_count, w_tx_count_nxt;
  logic                   w_tx_full, w_tx_push, w_tx_pop, r_tx_ovf;
  assign w_tx_full = (r_tx_count == TX_FULL);
  assign w_tx_push = w_commit && !w_tx_full;
  assign tx_valid  = (r_tx_count != '0);
  assign w_tx_pop  = tx_valid && tx_ready;
  assign tx_packet = tx_valid ? r_tx_mem[r_tx_rd] : '0;

  // TX storage write
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= w_stage_pkt;
  end

  // TX occupancy after this cycle's push/pop
  always_comb begin
    w_tx_count_nxt = r_tx_count;
    if (w_tx_push && !w_tx_pop)      w_tx_count_nxt = r_tx_count + TX_CW'(1);
    else if (!w_tx_push && w_tx_pop) w_tx_count_nxt = r_tx_count - TX_CW'(1);
  end

  // TX pointers, count and sticky overflow (a new overflow beats a STATUS-read clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wr <= '0; r_tx_rd <= '0; r_tx_count <= '0; r_tx_ovf <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + TX_AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_AW'(1);
      r_tx_count <= w_tx_count_nxt;
      if (w_commit && w_tx_full) r_tx_ovf <= 1'b1;
      else if (w_status_rd)      r_tx_ovf <= 1'b0;
    end
  end

  // RX FIFO. A POP in the same cycle frees the head slot, so a full FIFO
  // still accepts a packet on a POP cycle.
  logic [RX_W-1:0]  r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wr, r_rx_rd;
  logic [RX_CW-1:0] r_rx_count, w_rx_count_nxt;
  logic             w_rx_avail, w_rx_pop, w_rx_push, r_rx_irq;
  logic [RX_W-1:0]  w_rx_head;
  assign w_rx_avail = (r_rx_count != '0);
  assign w_rx_pop   = w_pop_req && w_rx_avail;
  assign rx_ready   = (r_rx_count != RX_FULL) || w_rx_pop;
  assign w_rx_push  = rx_valid && rx_ready;
  assign w_rx_head  = w_rx_avail ? r_rx_mem[r_rx_rd] : '0;
  assign rx_irq     = r_rx_irq;

  // RX storage write
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_packet[RX_W-1:0];
  end

  // RX occupancy after this cycle's push/pop
  always_comb begin
    w_rx_count_nxt = r_rx_count;
    if (w_rx_push && !w_rx_pop)      w_rx_count_nxt = r_rx_count + RX_CW'(1);
    else if (!w_rx_push && w_rx_pop) w_rx_count_nxt = r_rx_count - RX_CW'(1);
  end

  // RX pointers, count and the registered non-empty interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_wr <= '0; r_rx_rd <= '0; r_rx_count <= '0; r_rx_irq <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RX_AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_AW'(1);
      r_rx_count <= w_rx_count_nxt;
      r_rx_irq   <= (w_rx_count_nxt != '0);
    end
  end

`ifdef NETWORK_MMIO_COUNTERS_EN
  logic [31:0] r_tx_sent, r_rx_received, r_rx_bp;
  logic        w_cnt_clr;
  assign w_cnt_clr = w_wr && (w_word == 5'd17);

  // Event counters; a write to 0x44 clears all three and wins over an increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_sent <= '0; r_rx_received <= '0; r_rx_bp <= '0;
    end else if (w_cnt_clr) begin
      r_tx_sent <= '0; r_rx_received <= '0; r_rx_bp <= '0;
    end else begin
      if (w_tx_pop)             r_tx_sent     <= r_tx_sent + 32'd1;
      if (w_rx_push)            r_rx_received <= r_rx_received + 32'd1;
      if (rx_valid && !rx_ready) r_rx_bp       <= r_rx_bp + 32'd1;
    end
  end
`endif

  logic [31:0] w_status, w_rdata;
  logic [31:0] r_rdata;
  assign w_status  = {8'd0, 8'(r_rx_count), 8'(r_tx_count), 5'd0, r_tx_ovf, w_rx_avail, !w_tx_full};
  assign bus_rdata = r_rdata;

  // Read mux: staging readback, STATUS, RX head fields, optional counters
  always_comb begin
    w_rdata = '0;
    case (w_word)
      5'd0:  w_rdata = 32'(r_dest_x);
      5'd1:  w_rdata = 32'(r_dest_y);
      5'd2:  w_rdata = 32'(r_mcast);
      5'd3:  w_rdata = 32'({r_result, r_done});
      5'd4:  w_rdata = 32'(r_type);
      5'd5:  w_rdata = 32'(r_mx);
      5'd6:  w_rdata = 32'(r_my);
      5'd7:  w_rdata = 32'(r_element);
      5'd8:  w_rdata = w_status;
      5'd9:  w_rdata = 32'(w_rx_head[MC_LSB +: MULTICAST_GROUP_BITS]);
      5'd10: w_rdata = 32'({w_rx_head[RES_BIT], w_rx_head[DONE_BIT]});
      5'd11: w_rdata = 32'(w_rx_head[TY_LSB +: MATRIX_TYPE_BITS]);
      5'd12: w_rdata = 32'(w_rx_head[MX_LSB +: MATRIX_COORD_BITS]);
      5'd13: w_rdata = 32'(w_rx_head[MY_LSB +: MATRIX_COORD_BITS]);
      5'd14: w_rdata = 32'(w_rx_head[MATRIX_ELEMENT_BITS-1:0]);
`ifdef NETWORK_MMIO_COUNTERS_EN
      5'd17: w_rdata = r_tx_sent;
      5'd18: w_rdata = r_rx_received;
      5'd19: w_rdata = r_rx_bp;
`endif
      default: ;
    endcase
  end

  // Read data register: loads on a window read, otherwise holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdata;
  end

endmodule

// File: tb/tb_network_mmio_bridge.sv
// Bench for network_mmio_bridge: register map, TX/RX queueing, overflow,
// full-FIFO push+pop, counters and mid-operation reset.
module tb_network_mmio_bridge;

  localparam logic [31:0] BASE = 32'h1000_0100;
  localparam int TXD = 4;
  localparam int RXD = 4;
`ifdef NETWORK_MMIO_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        bus_write, bus_read;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_hit;
  logic [31:0] bus_rdata;
  logic [53:0] tx_packet;
  logic        tx_valid, tx_ready;
  logic [53:0] rx_packet;
  logic        rx_valid, rx_ready, rx_irq;

  network_mmio_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .bus_write(bus_write), .bus_read(bus_read), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_hit(bus_hit), .bus_rdata(bus_rdata),
    .tx_packet(tx_packet), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_packet(rx_packet), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_irq(rx_irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state / model ----------------
  int          checks = 0;
  int          failures = 0;
  bit          chk_en = 1'b0;
  logic [31:0] st[8];          // staging fields by word offset
  logic [63:0] exp_q[$];       // expected TX FIFO contents
  logic [63:0] rx_q[$];        // RX FIFO contents
  bit          ovf;
  logic [31:0] exp_rdata;
  logic [31:0] c_tx, c_rx, c_bp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] field_mask(input int i);
    int w;
    case (i)
      3: w = 2;
      5, 6: w = 8;
      7: w = 32;
      default: w = 1;
    endcase
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [63:0] pack_staging();
    logic [63:0] p;
    p = 64'(st[0]);
    p = (p << 1) | 64'(st[1]);
    p = (p << 1) | 64'(st[2]);
    p = (p << 1) | 64'(st[3][0]);   // done
    p = (p << 1) | 64'(st[3][1]);   // result
    p = (p << 1) | 64'(st[4]);
    p = (p << 8) | 64'(st[5]);
    p = (p << 8) | 64'(st[6]);
    p = (p << 32) | 64'(st[7]);
    return p;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] word);
    logic [63:0] h;
    int txs, rxs;
    txs = exp_q.size();
    rxs = rx_q.size();
    h = (rxs != 0) ? rx_q[0] : 64'd0;
    case (word)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: return st[word[2:0]];
      5'd8:  return 32'(txs < TXD) | (32'(rxs != 0) << 1) | (32'(ovf) << 2) |
                    (32'(txs) << 8) | (32'(rxs) << 16);
      5'd9:  return 32'(h[51]);
      5'd10: return 32'(h[50]) | (32'(h[49]) << 1);
      5'd11: return 32'(h[48]);
      5'd12: return 32'(h[47:40]);
      5'd13: return 32'(h[39:32]);
      5'd14: return h[31:0];
      5'd17: return CNT_EN ? c_tx : 32'd0;
      5'd18: return CNT_EN ? c_rx : 32'd0;
      5'd19: return CNT_EN ? c_bp : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) st[i] = 32'd0;
    exp_q.delete();
    rx_q.delete();
    ovf = 1'b0;
    exp_rdata = 32'd0;
    c_tx = 32'd0; c_rx = 32'd0; c_bp = 32'd0;
  endtask

  // One clock of bridge behaviour, evaluated from the inputs at the edge.
  task automatic model_step();
    logic [31:0] off;
    logic [4:0]  word;
    bit hit, pop_req, rx_rdy;
    int txs, rxs;
    off     = bus_addr - BASE;
    hit     = (off < 32'd128);
    word    = off[6:2];
    txs     = exp_q.size();
    rxs     = rx_q.size();
    pop_req = bus_write && hit && (word == 5'd16);
    rx_rdy  = (rxs < RXD) || pop_req;
    if (bus_read && hit) begin
      exp_rdata = model_read(word);
      if (word == 5'd8) ovf = 1'b0;
    end
    if (txs > 0 && tx_ready) begin
      void'(exp_q.pop_front());
      c_tx++;
    end
    if (rx_valid && !rx_rdy) c_bp++;
    if (bus_write && hit) begin
      if (word < 5'd8) st[word[2:0]] = bus_wdata & field_mask(int'(word));
      else if (word == 5'd8) begin
        if (txs < TXD) exp_q.push_back(pack_staging());
        else ovf = 1'b1;
      end else if (word == 5'd16) begin
        if (rxs > 0) void'(rx_q.pop_front());
      end
    end
    if (rx_valid && rx_rdy) begin
      rx_q.push_back(64'(rx_packet));
      c_rx++;
    end
    if (CNT_EN && bus_write && hit && word == 5'd17) begin
      c_tx = 32'd0; c_rx = 32'd0; c_bp = 32'd0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] off;
      bit pop_req;
      off     = bus_addr - BASE;
      pop_req = bus_write && (off < 32'd128) && (off[6:2] == 5'd16);
      check("bus_hit", 64'(bus_hit), 64'(off < 32'd128));
      check("tx_valid", 64'(tx_valid), 64'(exp_q.size() != 0));
      check("tx_packet", {10'd0, tx_packet}, (exp_q.size() != 0) ? exp_q[0] : 64'd0);
      check("rx_ready", 64'(rx_ready), 64'((rx_q.size() < RXD) || pop_req));
      check("rx_irq", 64'(rx_irq), 64'(rx_q.size() != 0));
      check("bus_rdata", 64'(bus_rdata), 64'(exp_rdata));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] d);
    bus_addr = BASE + off; bus_wdata = d; bus_write = 1'b1;
    cyc();
    bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] off);
    bus_addr = BASE + off; bus_read = 1'b1;
    cyc();
    bus_read = 1'b0;
  endtask

  task automatic rd_expect(input logic [31:0] off, input logic [31:0] exp, input string name);
    bus_rd(off);
    check(name, 64'(bus_rdata), 64'(exp));
  endtask

  task automatic rx_drive(input logic [31:0] el);
    rx_packet = {2'b11, 1'b1, 1'b1, 1'b0, 1'b1, el[7:0], 8'h0B, el};
  endtask

  task automatic rx_push(input logic [31:0] el);
    rx_drive(el);
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0; bus_write = 1'b0; bus_read = 1'b0; bus_addr = 32'd0; bus_wdata = 32'd0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_packet = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    rd_expect(32'h20, 32'h0000_0001, "reset_status");
    check("reset_rx_ready", 64'(rx_ready), 64'd1);
    check("reset_tx_valid", 64'(tx_valid), 64'd0);

    // Single TX packet held under backpressure
    bus_wr(32'h00, 32'd1);
    bus_wr(32'h14, 32'd3);
    bus_wr(32'h18, 32'd5);
    bus_wr(32'h1C, 32'hDEAD_BEEF);
    bus_wr(32'h20, 32'd0);
    check("commit_tx_valid", 64'(tx_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("tx_pkt_hold", {10'd0, tx_packet}, 64'h0020_0305_DEAD_BEEF);
      cyc();
    end
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check("tx_dequeued", 64'(tx_valid), 64'd0);

    // Staging readback, flag masking, unmapped and out-of-window accesses
    rd_expect(32'h1C, 32'hDEAD_BEEF, "stage_element");
    rd_expect(32'h00, 32'd1, "stage_dest_x");
    bus_wr(32'h0C, 32'hFF);
    rd_expect(32'h0C, 32'd3, "stage_flags");
    bus_wr(32'h3C, 32'h1234);
    rd_expect(32'h3C, 32'd0, "unmapped");
    bus_rd(32'h80);
    bus_rd(32'hFFFF_FFFC);
    check("outside_holds", 64'(bus_rdata), 64'd0);

    // TX overflow
    for (int i = 0; i < 5; i++) begin
      bus_wr(32'h1C, 32'd100 + 32'(i));
      bus_wr(32'h20, 32'd0);
    end
    rd_expect(32'h20, 32'h0000_0404, "status_overflow");
    rd_expect(32'h20, 32'h0000_0400, "status_ovf_cleared");
    tx_ready = 1'b1;
    repeat (5) cyc();
    tx_ready = 1'b0;

    // RX fill and drain
    for (int i = 0; i < 4; i++) rx_push(32'd10 + 32'(i));
    check("rx_full_ready", 64'(rx_ready), 64'd0);
    rd_expect(32'h28, 32'd1, "rx_flags");
    rd_expect(32'h30, 32'd10, "rx_mx");
    for (int i = 0; i < 4; i++) begin
      rd_expect(32'h38, 32'd10 + 32'(i), "rx_element");
      bus_wr(32'h40, 32'd0);
    end
    rd_expect(32'h38, 32'd0, "rx_empty_element");
    check("rx_empty_irq", 64'(rx_irq), 64'd0);
    bus_wr(32'h40, 32'd0);   // POP on empty is ignored

    // RX full: backpressure, then push and pop in one cycle
    for (int i = 0; i < 4; i++) rx_push(32'd20 + 32'(i));
    rx_drive(32'd24);
    rx_valid = 1'b1;
    cyc();
    cyc();
    bus_wr(32'h40, 32'd0);
    rx_valid = 1'b0;
    rd_expect(32'h20, 32'h0004_0003, "rx_pushpop_status");
    for (int i = 0; i < 4; i++) begin
      rd_expect(32'h38, 32'd21 + 32'(i), "rx_order");
      bus_wr(32'h40, 32'd0);
    end

    // Counters
    bus_wr(32'h44, 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) bus_wr(32'h20, 32'd0);
    cyc();
    tx_ready = 1'b0;
    rx_push(32'd31);
    rx_push(32'd32);
    rd_expect(32'h44, CNT_EN ? 32'd3 : 32'd0, "cnt_tx_sent");
    rd_expect(32'h48, CNT_EN ? 32'd2 : 32'd0, "cnt_rx_received");
    bus_rd(32'h4C);
    bus_wr(32'h44, 32'd0);
    rd_expect(32'h44, 32'd0, "cnt_tx_cleared");
    rd_expect(32'h48, 32'd0, "cnt_rx_cleared");

    // Reset mid-operation flushes both FIFOs and the staging registers
    bus_wr(32'h20, 32'd0);
    bus_wr(32'h20, 32'd0);
    rx_push(32'd33);
    reset_n = 1'b0;
    #2;
    check("midreset_tx_valid", 64'(tx_valid), 64'd0);
    check("midreset_rx_irq", 64'(rx_irq), 64'd0);
    check("midreset_rx_ready", 64'(rx_ready), 64'd1);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    rd_expect(32'h20, 32'h0000_0001, "post_reset_status");
    rd_expect(32'h1C, 32'd0, "post_reset_staging");
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/network_mmio_bridge.md
# network_mmio_bridge

Memory-mapped bridge between a PicoRV32 look-ahead bus and one Hoplite network port, replacing per-field strobes with a staged TX packet register, a TX FIFO and an RX FIFO of configurable depth. The CPU writes packet fields, then commits the whole packet. It pops received packets after reading their fields. The bridge sits beside node RAM in each node's `system`, and the system muxes `bus_rdata` when `bus_hit` is set.

## Interface
- `BASE_ADDR`, 32'h1000_0100: byte base of the register window; 32-byte aligned.
- `COORD_BITS`, 1: destination x/y width.
- `MULTICAST_GROUP_BITS`, 1: multicast group width.
- `MATRIX_TYPE_BITS`, 1: matrix type width.
- `MATRIX_COORD_BITS`, 8: matrix x/y coordinate width.
- `MATRIX_ELEMENT_BITS`, 32: element width; ≤32.
- `TX_DEPTH`, 4: TX FIFO entries; power of two, 2..128.
- `RX_DEPTH`, 4: RX FIFO entries; power of two, 2..128.
- `PACKET_BITS`, derived: 2*COORD + MCAST + 2 + TYPE + 2*MCOORD + ELEMENT.
- `clk` in 1: single clock.
- `reset_n` in 1: reset, **asynchronous, active-low**.
- `bus_write` in 1: `mem_la_write`.
- `bus_read` in 1: `mem_la_read`.
- `bus_addr` in 32: `mem_la_addr`.
- `bus_wdata` in 32: `mem_la_wdata`.
- `bus_hit` out 1: combinational; address is within the 128-byte window.
- `bus_rdata` out 32: registered read data.
- `tx_packet` out PACKET_BITS: TX FIFO head.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: network accepts the head.
- `rx_packet` in PACKET_BITS: incoming packet; its dest x/y fields are ignored.
- `rx_valid` in 1: incoming packet present.
- `rx_ready` out 1: RX FIFO not full.
- `rx_irq` out 1: registered; RX FIFO non-empty.

## Operation
- Packet packing, MSB→LSB: dest_x, dest_y, mcast, done, result, type, mx, my, element.
- Write registers (byte offset from BASE_ADDR):
  - 0x00 dest_x; 0x04 dest_y; 0x08 mcast.
  - 0x0C flags: bit0 done, bit1 result.
  - 0x10 type; 0x14 mx; 0x18 my; 0x1C element.
  - 0x20 COMMIT: push staging into the TX FIFO.
  - 0x40 POP: discard the RX head.
- Write behaviour:
  - Field writes take the low bits of `bus_wdata`.
  - Staging registers persist after COMMIT; only changed fields need rewriting.
- Read registers:
  - 0x20 STATUS: [0] tx_not_full, [1] rx_available, [2] tx_overflow (sticky), [15:8] tx_count, [23:16] rx_count.
  - Reading STATUS clears tx_overflow.
  - 0x24 mcast; 0x28 flags; 0x2C type; 0x30 mx; 0x34 my; 0x38 element. These are RX head fields, zero-extended, and read 0 when RX is empty.
  - 0x00–0x1C read back the staging registers.
  - Unmapped offsets inside the window read 0 and ignore writes.
- COMMIT when TX is full:
  - Packet dropped, tx_overflow set.
  - TX pop in the same cycle does not rescue it; fullness is the registered state.
- POP when RX is empty: ignored.
- TX dequeue on `tx_valid && tx_ready`; RX enqueue on `rx_valid && rx_ready`.
- Simultaneous push+pop on either FIFO: count unchanged, both take effect.
- Reset mid-operation: both FIFOs flushed immediately, in-flight packets lost.

## Timing
- `bus_rdata` is valid on the cycle after `bus_read`, matching the FAST_MEMORY RAM. Otherwise it holds its last value; reset value 0.
- Latencies:
  - Write to staging: visible to reads the next cycle.
  - COMMIT: `tx_valid` high the next cycle; `tx_packet` equals the staging contents at COMMIT.
  - RX enqueue to `rx_irq`/STATUS[1]: 1 cycle. POP to the new head on the field reads: 1 cycle.
- Reset values:
  - `bus_rdata`, `tx_valid`, `rx_irq`, counts, tx_overflow, staging: all 0.
  - `tx_packet` 0; `rx_ready` 1.
- `tx_packet` must hold stable while `tx_valid && !tx_ready`.
- Pointers wrap modulo depth. Counts are log2(depth)+1 bits, so a full FIFO reads as DEPTH.

## Configuration
- `NETWORK_MMIO_COUNTERS_EN` defined:
  - 32-bit tx_sent (TX dequeues), rx_received (RX enqueues) and rx_backpressure (cycles with `rx_valid && !rx_ready`) counters, readable at 0x44, 0x48 and 0x4C.
  - Counters wrap at 2^32, reset to 0, and are cleared by any write to 0x44.
- Undefined: counters absent; 0x44–0x4C read 0.

## Test plan
- Reset, then read STATUS → `bus_rdata`=0x0000_0001 the next cycle; `rx_ready`=1, `tx_valid`=0.
- Write dest_x=1, mx=3, my=5, element=0xDEADBEEF, COMMIT, with `tx_ready`=0 → `tx_valid`=1 the next cycle, packet fields exact and held for 10 cycles; raise `tx_ready` → dequeued, `tx_valid`=0.
- TX_DEPTH=4, `tx_ready`=0, 5 COMMITs → STATUS=0x0000_0404 (count 4, overflow set); a second STATUS read gives 0x0000_0400.
- Drive 4 RX packets with element 10..13, RX_DEPTH=4 → `rx_ready`=0; read element/POP loop returns 10, 11, 12, 13, then reads 0 with `rx_irq`=0.
- RX full with `rx_valid` held and POP issued → that cycle's pop and enqueue both occur; rx_count stays 4 and the order is preserved.
- With `NETWORK_MMIO_COUNTERS_EN`: 3 TX dequeues and 2 RX enqueues → 0x44=3, 0x48=2; a write to 0x44 zeroes both.
